// File: rtl/alu_arbiter.sv
// Two-requester front end for the shared combinational ALU.
// Round-robin grant, registered operands, registered result with a trace strobe.
module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int FUNC_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req0_A,
  input  logic [WIDTH-1:0]  req1_A,
  input  logic [WIDTH-1:0]  req0_B,
  input  logic [WIDTH-1:0]  req1_B,
  input  logic              req0_Signed,
  input  logic              req1_Signed,
  input  logic [FUNC_W-1:0] req0_ALUFunc,
  input  logic [FUNC_W-1:0] req1_ALUFunc,
  output logic [WIDTH-1:0]  alu_A,
  output logic [WIDTH-1:0]  alu_B,
  output logic              alu_Signed,
  output logic [FUNC_W-1:0] alu_ALUFunc,
  input  logic [WIDTH-1:0]  alu_S,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  input  logic              rsp0_ready,
  input  logic              rsp1_ready,
  output logic [WIDTH-1:0]  rsp_S,
  output logic              alu_pulse,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t state, state_nx;

  logic              last;
  logic              owner;
  logic              pulse;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  s_q;
  logic              sg_q;
  logic [FUNC_W-1:0] f_q;
  logic              grant0;
  logic              grant1;
  logic              accept;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    unique case (1'b1)
      (req0_valid && req1_valid): begin
        grant0 = last;
        grant1 = !last;
      end
      (req0_valid && !req1_valid): grant0 = 1'b1;
      (!req0_valid && req1_valid): grant1 = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_nx   = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        accept     = grant0 || grant1;
        if (accept) state_nx = EXEC;
      end
      EXEC: state_nx = RESP;
      RESP: begin
        if (owner ? rsp1_ready : rsp0_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last  <= 1'b1;
      owner <= 1'b0;
      pulse <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      sg_q  <= 1'b0;
      f_q   <= '0;
      s_q   <= '0;
    end else begin
      state <= state_nx;
      pulse <= (state == EXEC);
      if (accept) begin
        a_q   <= grant1 ? req1_A : req0_A;
        b_q   <= grant1 ? req1_B : req0_B;
        sg_q  <= grant1 ? req1_Signed : req0_Signed;
        f_q   <= grant1 ? req1_ALUFunc : req0_ALUFunc;
        owner <= grant1;
        last  <= grant1;
      end
      if (state == EXEC) s_q <= alu_S;
    end
  end

  assign alu_A       = a_q;
  assign alu_B       = b_q;
  assign alu_Signed  = sg_q;
  assign alu_ALUFunc = f_q;
  assign rsp_S       = s_q;
  assign rsp0_valid  = (state == RESP) && !owner;
  assign rsp1_valid  = (state == RESP) && owner;
  assign alu_pulse   = pulse;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed table, multi-cycle corner cases,
// then random traffic against a transaction-level reference model.
module tb_alu_arbiter;

  localparam logic [5:0] F_ADD = 6'b000000;
  localparam logic [5:0] F_SUB = 6'b000010;
  localparam logic [5:0] F_AND = 6'b001000;
  localparam logic [5:0] F_SLL = 6'b010000;
  localparam logic [5:0] F_LT  = 6'b110101;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic v0 = 0, v1 = 0, rr0 = 0, rr1 = 0;
  logic [31:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic s0 = 0, s1 = 0;
  logic [5:0] f0 = 0, f1 = 0;
  logic ready0, ready1, rv0, rv1, pulse, busy, alu_sg;
  logic [31:0] alu_a, alu_b, alu_s, rsp_s;
  logic [5:0] alu_f;

  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(logic [31:0] a, logic [31:0] b,
                                         logic sg, logic [5:0] f);
    case (f)
      F_ADD: return a + b;
      F_SUB: return a - b;
      F_AND: return a & b;
      F_SLL: return a << b[4:0];
      F_LT:  return sg ? {31'b0, $signed(a) < $signed(b)} : {31'b0, a < b};
      default: return a ^ b ^ {26'b0, f};
    endcase
  endfunction

  assign alu_s = alu_fn(alu_a, alu_b, alu_sg, alu_f);

  alu_arbiter #(.WIDTH(32), .FUNC_W(6)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(v0), .req1_valid(v1),
    .req0_ready(ready0), .req1_ready(ready1),
    .req0_A(a0), .req1_A(a1), .req0_B(b0), .req1_B(b1),
    .req0_Signed(s0), .req1_Signed(s1),
    .req0_ALUFunc(f0), .req1_ALUFunc(f1),
    .alu_A(alu_a), .alu_B(alu_b), .alu_Signed(alu_sg), .alu_ALUFunc(alu_f),
    .alu_S(alu_s),
    .rsp0_valid(rv0), .rsp1_valid(rv1),
    .rsp0_ready(rr0), .rsp1_ready(rr1),
    .rsp_S(rsp_s), .alu_pulse(pulse), .busy(busy)
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic run_op(input bit who, input logic [31:0] a, input logic [31:0] b,
                        input logic sg, input logic [5:0] f,
                        input logic [31:0] exp, input bit alt);
    @(negedge clk);
    rr0 = 1; rr1 = 1;
    if (who) begin v1 = 1; a1 = a; b1 = b; s1 = sg; f1 = f; end
    else     begin v0 = 1; a0 = a; b0 = b; s0 = sg; f0 = f; end
    #1 chk("op_ready", who ? ready1 : ready0, 1);
    @(negedge clk);
    v0 = 0; v1 = 0;
    if (alt) begin if (who) a1 = 99; else a0 = 99; end
    #1;
    chk("op_exec_busy", busy, 1);
    chk("op_exec_alu", {alu_sg, alu_f, alu_a, alu_b}, {sg, f, a, b});
    chk("op_exec_quiet", {rv1, rv0, pulse}, 0);
    @(negedge clk);
    #1;
    chk("op_rsp_valid", {rv1, rv0}, who ? 2'b10 : 2'b01);
    chk("op_rsp_S", rsp_s, exp);
    chk("op_pulse", pulse, 1);
    @(negedge clk);
    #1 chk("op_done_idle", busy, 0);
  endtask

  typedef struct {
    bit          who;
    logic [31:0] a;
    logic [31:0] b;
    logic        sg;
    logic [5:0]  f;
    logic [31:0] exp;
    bit          alt;
  } vec_t;

  vec_t tbl[6];

  // reference model state
  int          m_ph;
  bit          m_last, m_own, m_first;
  logic [31:0] m_a, m_b, m_res;
  logic        m_sg;
  logic [5:0]  m_f;

  initial begin
    int acc, pc, t0, t1;
    bit seq[$];
    logic [5:0] codes[6];

    tbl[0] = '{0, 32'd5, 32'd7, 1, F_ADD, 32'd12, 0};
    tbl[1] = '{1, 32'd3, 32'd10, 0, F_SUB, 32'hFFFF_FFF9, 0};
    tbl[2] = '{0, 32'hFFFF_FFFF, 32'd0, 0, F_LT, 32'd0, 0};
    tbl[3] = '{1, 32'hFFFF_FFFF, 32'd0, 1, F_LT, 32'd1, 0};
    tbl[4] = '{0, 32'd5, 32'd7, 1, F_ADD, 32'd12, 1};
    tbl[5] = '{1, 32'd1, 32'd2, 0, 6'h3F, 32'h3C, 0};

    do_reset();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ready", {ready1, ready0}, 0);
    chk("rst_rsp", {rv1, rv0, pulse}, 0);
    chk("rst_regs", {alu_sg, alu_f, alu_a, alu_b}, 0);
    chk("rst_rsp_S", rsp_s, 0);

    foreach (tbl[i])
      run_op(tbl[i].who, tbl[i].a, tbl[i].b, tbl[i].sg, tbl[i].f,
             tbl[i].exp, tbl[i].alt);

    // both requesters pending from reset: strict alternation from req0
    do_reset();
    acc = 0; pc = 0; t0 = -1; t1 = -1;
    v0 = 1; a0 = 10; b0 = 3; s0 = 0; f0 = F_SUB;
    v1 = 1; a1 = 32'hF0F0_F0F0; b1 = 32'h0FF0_0FF0; s1 = 0; f1 = F_AND;
    rr0 = 1; rr1 = 1;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      if (acc >= 8) begin v0 = 0; v1 = 0; end
      #1;
      if ((v0 && ready0) || (v1 && ready1)) begin
        if (acc == 0) t0 = k;
        if (acc == 1) t1 = k;
        acc++;
      end
      if (rv0) begin seq.push_back(0); chk("alt_S0", rsp_s, 32'd7); end
      if (rv1) begin seq.push_back(1); chk("alt_S1", rsp_s, 32'h00F0_00F0); end
      if (pulse) pc++;
    end
    chk("alt_pulses", pc, 8);
    chk("alt_count", seq.size(), 8);
    chk("alt_spacing", t1 - t0, 3);
    foreach (seq[i]) chk("alt_owner", seq[i], i % 2);

    // backpressure on req1 while req0 waits
    @(negedge clk);
    v1 = 1; a1 = 1; b1 = 4; s1 = 0; f1 = F_SLL; rr1 = 0; rr0 = 1;
    #1 chk("bp_accept", ready1, 1);
    @(negedge clk);
    v1 = 0; v0 = 1; a0 = 0; b0 = 0; f0 = F_ADD;
    #1 chk("bp_exec", {busy, ready0}, 2'b10);
    @(negedge clk);
    #1;
    chk("bp_first", {rv1, pulse, ready0}, 3'b110);
    chk("bp_first_S", rsp_s, 32'd16);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("bp_hold", {rv1, rv0, pulse, ready0, ready1}, 5'b10000);
      chk("bp_hold_S", rsp_s, 32'd16);
    end
    rr1 = 1;
    @(negedge clk);
    #1 chk("bp_release", {rv1, ready0}, 2'b01);
    v0 = 0;

    // reset while in EXEC discards the operation
    @(negedge clk);
    v0 = 1; a0 = 3; b0 = 4; f0 = F_ADD; rr0 = 1;
    @(negedge clk);
    v0 = 0;
    #1 chk("rx_exec", busy, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    #1;
    chk("rx_idle", busy, 0);
    chk("rx_rsp_S", rsp_s, 0);
    pc = 0;
    for (int i = 0; i < 3; i++) begin
      if (rv0 || rv1 || pulse) pc++;
      @(negedge clk);
      #1;
    end
    chk("rx_silent", pc, 0);
    run_op(1, 32'hFFFF_FFFF, 32'd0, 1, F_LT, 32'd1, 0);

    // random traffic against the reference model
    codes = '{F_ADD, F_SUB, F_AND, F_SLL, F_LT, 6'h2A};
    for (int k = 0; k < 500; k++) begin
      bit g0, g1;
      @(negedge clk);
      reset = (k == 0) || ($urandom_range(0, 60) == 0);
      v0 = 1'($urandom); v1 = 1'($urandom);
      a0 = $urandom; b0 = $urandom; s0 = 1'($urandom);
      a1 = $urandom; b1 = $urandom; s1 = 1'($urandom);
      f0 = ($urandom_range(0, 7) == 0) ? 6'($urandom) : codes[$urandom_range(0, 5)];
      f1 = ($urandom_range(0, 7) == 0) ? 6'($urandom) : codes[$urandom_range(0, 5)];
      rr0 = ($urandom_range(0, 3) != 0);
      rr1 = ($urandom_range(0, 3) != 0);
      g0 = v0 && (!v1 || m_last);
      g1 = v1 && (!v0 || !m_last);
      #1;
      if (k > 0) begin
        chk("rnd_ready", {ready1, ready0}, (m_ph == 0) ? {g1, g0} : 2'b00);
        chk("rnd_rsp_valid", {rv1, rv0},
            (m_ph == 2) ? (m_own ? 2'b10 : 2'b01) : 2'b00);
        chk("rnd_pulse", pulse, m_ph == 2 && m_first);
        chk("rnd_busy", busy, m_ph != 0);
        chk("rnd_rsp_S", rsp_s, m_res);
        chk("rnd_alu", {alu_sg, alu_f, alu_a, alu_b}, {m_sg, m_f, m_a, m_b});
      end
      @(posedge clk);
      if (reset) begin
        m_ph = 0; m_last = 1; m_own = 0; m_first = 0;
        m_a = 0; m_b = 0; m_sg = 0; m_f = 0; m_res = 0;
      end else if (m_ph == 0) begin
        if (g0 || g1) begin
          m_own = g1; m_last = g1; m_ph = 1;
          m_a = g1 ? a1 : a0; m_b = g1 ? b1 : b0;
          m_sg = g1 ? s1 : s0; m_f = g1 ? f1 : f0;
        end
      end else if (m_ph == 1) begin
        m_res = alu_fn(m_a, m_b, m_sg, m_f);
        m_ph = 2; m_first = 1;
      end else begin
        m_first = 0;
        if (m_own ? rr1 : rr0) m_ph = 0;
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

- Shares the single combinational ALU (operands `A`/`B`, `Signed`, 6-bit `ALUFunc`, result `S`) between two requesters, e.g. the execute stage and the multi-cycle branch/compare helper.
- Accepts one operation at a time through a valid/ready handshake, with round-robin arbitration on conflict.
- Drives the ALU from registered operands and captures `S` into a response register.
- Emits a one-cycle `alu_pulse` per completed operation, usable as the posedge trigger of the ALU trace printer.

## Interface

Parameters:
- `WIDTH`, 32, operand/result width.
- `FUNC_W`, 6, ALUFunc width.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `req0_valid`, `req1_valid`  in  1  requester has an operation pending.
- `req0_ready`, `req1_ready`  out  1  operation accepted this cycle when ready and valid are both 1.
- `req0_A`, `req1_A`  in  WIDTH  operand A.
- `req0_B`, `req1_B`  in  WIDTH  operand B.
- `req0_Signed`, `req1_Signed`  in  1  signed/unsigned select.
- `req0_ALUFunc`, `req1_ALUFunc`  in  FUNC_W  ALU function code.
- `alu_A`, `alu_B`  out  WIDTH  to ALU operand inputs.
- `alu_Signed`  out  1  to ALU.
- `alu_ALUFunc`  out  FUNC_W  to ALU.
- `alu_S`  in  WIDTH  ALU result (combinational from `alu_*`).
- `rsp0_valid`, `rsp1_valid`  out  1  result available for that requester.
- `rsp0_ready`, `rsp1_ready`  in  1  requester consumes result.
- `rsp_S`  out  WIDTH  registered result, shared by both response channels.
- `alu_pulse`  out  1  one-cycle strobe, high in the first RESP cycle.
- `busy`  out  1  high whenever state is not IDLE.

## Operation

- FSM states: IDLE, EXEC, RESP.
- Grant in IDLE:
  - Combinational from the valids and the `last` pointer.
  - Only one valid: that requester is granted.
  - Both valid: the requester ≠ `last` is granted.
  - `reqN_ready` = (state == IDLE) && grant == N. Both readys are 0 outside IDLE.
- Transitions:
  - IDLE → EXEC on accept. Latch A, B, Signed, ALUFunc and owner ID; set `last` := owner.
  - EXEC → RESP unconditionally. Latch `alu_S` into `rsp_S`.
  - RESP → IDLE when `rsp<owner>_ready` = 1. Otherwise stay in RESP; `rsp_S` and the owner are held stable.
- Outputs by state:
  - `rspN_valid` = (state == RESP) && owner == N.
  - `rsp_ready` of the non-owner is ignored.
- ALU drive:
  - `alu_*` are always driven from the operand registers.
  - They hold their values through EXEC and RESP, so `alu_A`/`alu_B`/`alu_S` remain coherent at the `alu_pulse` edge.
- ALUFunc codes pass through unchecked. Undefined codes still complete, with whatever `alu_S` the ALU returns.
- Width rules: no arithmetic inside the block; values are copied bit-exact.
- Reset values:
  - state = IDLE, `last` = 1 (so req0 wins the first tie), owner = 0.
  - Operand registers, `rsp_S` = 0.
  - `alu_pulse`, `rsp*_valid`, `busy` = 0.

## Timing

- Accept in cycle t → EXEC in t+1 → `rspN_valid`, `rsp_S` and `alu_pulse` high in t+2.
- Minimum latency: 2 cycles from accept to response.
- Maximum throughput: one operation per 3 cycles (rsp consumed at t+2, next accept at t+3).
- Operand/ALUFunc inputs are sampled only on the accept edge. Changes after accept have no effect.
- `alu_pulse` is high exactly one cycle per operation, even if RESP is held for many cycles.
- Requester deasserts valid while in IDLE without being granted: no effect.
- Reset:
  - Asserted in any state: next cycle is IDLE with all reset values; an in-flight operation is discarded and produces no response or pulse.
  - Reset wins over a simultaneous accept or response handshake.
- Both valid continuously with readys held high: grants strictly alternate 0,1,0,1…

## Test plan

- req0 ADD (`000000`), A=5, B=7, Signed=1, accepted at t → `alu_A`=5, `alu_B`=7 from t+1; `rsp0_valid`=1, `rsp_S`=12, `alu_pulse`=1 at t+2; `rsp1_valid`=0 throughout.
- req0 and req1 valid together from reset (req0 SUB 10−3, req1 AND `0xF0F0_F0F0`&`0x0FF0_0FF0`), `rsp_ready`s held 1 → req0 served first (`rsp_S`=7), then req1 (`rsp_S`=`0x00F0_00F0`); accepts at t and t+3.
- Backpressure: req1 SLL A=1, B=4, `rsp1_ready`=0 for 5 cycles after t+2 → `rsp1_valid` and `rsp_S`=16 stable for 5 cycles, `alu_pulse` high only at t+2, `req*_ready`=0 until RESP exits.
- Both valid for 8 operations with readys always 1 → owner sequence 0,1,0,1,0,1,0,1 and 8 `alu_pulse` strobes.
- Reset asserted in EXEC → next cycle `busy`=0, no `rsp*_valid` or `alu_pulse` ever issued for that op; a following req1 LT (`110101`) with A=−1, B=0, Signed=1 → `rsp_S`=1.
- Input change after accept: req0 alters A from 5 to 99 in t+1 → `rsp_S` reflects A=5.
